// File: rtl/beverage_sequencer.sv
// Recipe sequencer: debounced buttons pick a recipe and run its enabled ingredient valves on a tick base.
// Outputs are registered; a select event in cycle t shows busy and the first valve in t+1; no backpressure.
module beverage_sequencer #(
   parameter int                       N_RECIPES  = 4,
   parameter logic [N_RECIPES*5-1:0]   RECIPE_MASK = 20'h7FCE3,
   parameter int                       TICK_DIV   = 50000000,
   parameter int                       STEP_TICKS = 3,
   parameter int                       FIN_TICKS  = 2,
   parameter int                       DEB_CYCLES = 1000000,
   parameter int                       CNT_W      = 8,
   localparam int                      RW         = $clog2(N_RECIPES)
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             next_n,
   input  logic             select_n,
   input  logic             cancel_n,
   output logic [RW-1:0]    recipe_sel,
   output logic [2:0]       step_code,
   output logic [4:0]       valve,
   output logic             busy,
   output logic             done,
   output logic             aborted,
   output logic [CNT_W-1:0] brew_count
);

   localparam int NXT = 0;
   localparam int SEL = 1;
   localparam int CAN = 2;

   localparam int DW = $clog2(DEB_CYCLES + 1);
   localparam int TW = $clog2(TICK_DIV + 1);
   localparam int KW = $clog2(((STEP_TICKS > FIN_TICKS) ? STEP_TICKS : FIN_TICKS) + 1);

   localparam logic [DW-1:0] DEB_LAST  = DW'(DEB_CYCLES - 1);
   localparam logic [TW-1:0] TICK_LAST = TW'(TICK_DIV - 1);
   localparam logic [KW-1:0] STEP_LAST = KW'(STEP_TICKS - 1);
   localparam logic [KW-1:0] FIN_LAST  = KW'(FIN_TICKS - 1);
   localparam logic [RW-1:0] SEL_LAST  = RW'(N_RECIPES - 1);

   typedef enum logic [1:0] {S_IDLE, S_STEP, S_FINISH} state_t;

   logic [2:0]    raw;
   logic [2:0]    sync1_q, sync2_q, deb_q, press_q;
   logic [DW-1:0] deb_cnt_q [3];

   logic [TW-1:0] presc_q;
   logic          tick;
   logic          brew_start;

   state_t        state_q;
   logic [RW-1:0] recipe_q;
   logic [4:0]    act_mask_q;
   logic [2:0]    step_q;
   logic [KW-1:0] tcnt_q;
   logic [2:0]    code_q;
   logic [4:0]    valve_q;
   logic          busy_q, done_q, abort_q;
   logic [CNT_W-1:0] count_q;

   logic [3:0]       first_hit, next_hit;
   logic [CNT_W-1:0] count_d;

   // Lowest enabled step at or above lo, as {found, index}.
   function automatic logic [3:0] find_step(input logic [4:0] m, input logic [2:0] lo);
      logic [3:0] r;
      r = '0;
      for (int i = 4; i >= 0; i--) begin
         if (m[i] && (3'(i) >= lo)) r = {1'b1, 3'(i)};
      end
      return r;
   endfunction

   function automatic logic [4:0] mask_of(input logic [RW-1:0] r);
      logic [4:0] m;
      m = '0;
      for (int i = 0; i < N_RECIPES; i++) begin
         if (r == RW'(i)) m = RECIPE_MASK[i*5 +: 5];
      end
      return m;
   endfunction

   assign raw = {cancel_n, select_n, next_n};

   // Level only moves after DEB_CYCLES straight disagreeing cycles; the press pulse rides on the 1->0 update.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         sync1_q <= '1;
         sync2_q <= '1;
         deb_q   <= '1;
         press_q <= '0;
         for (int b = 0; b < 3; b++) deb_cnt_q[b] <= '0;
      end else begin
         sync1_q <= raw;
         sync2_q <= sync1_q;
         for (int b = 0; b < 3; b++) begin
            press_q[b] <= 1'b0;
            if (sync2_q[b] == deb_q[b]) begin
               deb_cnt_q[b] <= '0;
            end else if (deb_cnt_q[b] == DEB_LAST) begin
               deb_cnt_q[b] <= '0;
               deb_q[b]     <= sync2_q[b];
               press_q[b]   <= ~sync2_q[b];
            end else begin
               deb_cnt_q[b] <= deb_cnt_q[b] + 1'b1;
            end
         end
      end
   end

   assign tick       = (presc_q == TICK_LAST);
   assign brew_start = (state_q == S_IDLE) && press_q[SEL];

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         presc_q <= '0;
      end else if (brew_start || tick) begin
         presc_q <= '0;
      end else begin
         presc_q <= presc_q + 1'b1;
      end
   end

   assign first_hit = find_step(mask_of(recipe_q), 3'd0);
   assign next_hit  = find_step(act_mask_q, step_q + 3'd1);
   assign count_d   = (count_q == '1) ? count_q : count_q + 1'b1;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q    <= S_IDLE;
         recipe_q   <= '0;
         act_mask_q <= '0;
         step_q     <= '0;
         tcnt_q     <= '0;
         code_q     <= '0;
         valve_q    <= '0;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
         abort_q    <= 1'b0;
         count_q    <= '0;
      end else begin
         abort_q <= 1'b0;
         case (state_q)
            S_IDLE: begin
               // Select wins over next and cancel in the same cycle.
               if (press_q[SEL]) begin
                  act_mask_q <= mask_of(recipe_q);
                  tcnt_q     <= '0;
                  busy_q     <= 1'b1;
                  if (first_hit[3]) begin
                     state_q <= S_STEP;
                     step_q  <= first_hit[2:0];
                     code_q  <= first_hit[2:0] + 3'd1;
                     valve_q <= 5'd1 << first_hit[2:0];
                  end else begin
                     state_q <= S_FINISH;
                     code_q  <= 3'd6;
                     done_q  <= 1'b1;
                     count_q <= count_d;
                  end
               end else if (press_q[NXT]) begin
                  recipe_q <= (recipe_q == SEL_LAST) ? '0 : recipe_q + 1'b1;
               end
            end
            S_STEP: begin
               if (press_q[CAN]) begin
                  state_q <= S_IDLE;
                  code_q  <= '0;
                  valve_q <= '0;
                  busy_q  <= 1'b0;
                  abort_q <= 1'b1;
               end else if (tick) begin
                  if (tcnt_q == STEP_LAST) begin
                     tcnt_q <= '0;
                     if (next_hit[3]) begin
                        step_q  <= next_hit[2:0];
                        code_q  <= next_hit[2:0] + 3'd1;
                        valve_q <= 5'd1 << next_hit[2:0];
                     end else begin
                        state_q <= S_FINISH;
                        code_q  <= 3'd6;
                        valve_q <= '0;
                        done_q  <= 1'b1;
                        count_q <= count_d;
                     end
                  end else begin
                     tcnt_q <= tcnt_q + 1'b1;
                  end
               end
            end
            S_FINISH: begin
               if (press_q[CAN] || (tick && (tcnt_q == FIN_LAST))) begin
                  state_q <= S_IDLE;
                  tcnt_q  <= '0;
                  code_q  <= '0;
                  busy_q  <= 1'b0;
                  done_q  <= 1'b0;
               end else if (tick) begin
                  tcnt_q <= tcnt_q + 1'b1;
               end
            end
            default: state_q <= S_IDLE;
         endcase
      end
   end

   assign recipe_sel = recipe_q;
   assign step_code  = code_q;
   assign valve      = valve_q;
   assign busy       = busy_q;
   assign done       = done_q;
   assign aborted    = abort_q;
   assign brew_count = count_q;

endmodule

// File: tb/tb_beverage_sequencer.sv
// Randomised bench for beverage_sequencer; expected waveforms are built from recipe masks and tick arithmetic.
module tb_beverage_sequencer;

   localparam int N        = 3;
   localparam logic [14:0] MASKS = {5'b00000, 5'b11111, 5'b00011};
   localparam int TDIV     = 4;
   localparam int STEPT    = 2;
   localparam int FINT     = 3;
   localparam int DEB      = 2;
   localparam int CW       = 2;
   localparam int STEP_CYC = STEPT * TDIV;
   localparam int FIN_CYC  = FINT * TDIV;
   localparam int CNT_MAX  = (1 << CW) - 1;

   logic          clk = 1'b0;
   logic          reset = 1'b1;
   logic          next_n = 1'b1;
   logic          select_n = 1'b1;
   logic          cancel_n = 1'b1;
   logic [1:0]    recipe_sel;
   logic [2:0]    step_code;
   logic [4:0]    valve;
   logic          busy, done, aborted;
   logic [CW-1:0] brew_count;

   int checks = 0;
   int errors = 0;
   int model_sel = 0;
   int model_brews = 0;

   beverage_sequencer #(
      .N_RECIPES(N), .RECIPE_MASK(MASKS), .TICK_DIV(TDIV), .STEP_TICKS(STEPT),
      .FIN_TICKS(FINT), .DEB_CYCLES(DEB), .CNT_W(CW)
   ) dut (
      .clk(clk), .reset(reset), .next_n(next_n), .select_n(select_n), .cancel_n(cancel_n),
      .recipe_sel(recipe_sel), .step_code(step_code), .valve(valve), .busy(busy),
      .done(done), .aborted(aborted), .brew_count(brew_count)
   );

   always #5 clk = ~clk;

   function automatic logic [12:0] obs();
      return {recipe_sel, busy, done, aborted, step_code, valve};
   endfunction

   function automatic logic [4:0] model_mask(input int r);
      logic [14:0] all;
      all = MASKS;
      return all[r*5 +: 5];
   endfunction

   function automatic logic [CW-1:0] exp_count();
      return CW'((model_brews > CNT_MAX) ? CNT_MAX : model_brews);
   endfunction

   task automatic press_next();
      next_n = 1'b0;
      repeat ($urandom_range(4, 7)) @(negedge clk);
      next_n = 1'b1;
      repeat ($urandom_range(5, 8)) @(negedge clk);
      model_sel = (model_sel + 1) % N;
   endtask

   task automatic goto_recipe(input int r);
      while (model_sel != r) begin
         press_next();
         checks++;
         if (recipe_sel !== 2'(model_sel)) begin
            errors++;
            $display("FAIL goto_recipe recipe_sel=%0d expected %0d", recipe_sel, model_sel);
         end
      end
   endtask

   task automatic run_brew(input bit mid_presses, input bit do_cancel);
      logic [12:0] exp_q[$];
      logic [12:0] got;
      logic [4:0]  m;
      int tmo, cd, seen;
      logic [CW-1:0] count_before;
      m = model_mask(model_sel);
      for (int s = 0; s < 5; s++)
         if (m[s])
            for (int c = 0; c < STEP_CYC; c++)
               exp_q.push_back({2'(model_sel), 3'b100, 3'(s + 1), 5'(1 << s)});
      for (int c = 0; c < FIN_CYC; c++)
         exp_q.push_back({2'(model_sel), 3'b110, 3'd6, 5'd0});
      cd   = STEP_CYC + $urandom_range(0, 2);
      seen = 0;
      count_before = brew_count;

      select_n = 1'b0;
      tmo = 0;
      do begin
         @(negedge clk);
         tmo++;
      end while (busy !== 1'b1 && tmo < 20);
      select_n = 1'b1;
      checks++;
      if (busy !== 1'b1) begin
         errors++;
         $display("FAIL brew_start busy=%b expected 1 within 20 cycles", busy);
         return;
      end

      for (int k = 0; k < exp_q.size(); k++) begin
         got = obs();
         if (do_cancel && aborted === 1'b1) begin
            checks++;
            if (got !== {2'(model_sel), 3'b001, 3'd0, 5'd0} || k < cd + 3 || k > cd + 8) begin
               errors++;
               $display("FAIL cancel_abort got=%h at k=%0d expected %h in k=%0d..%0d",
                        got, k, {2'(model_sel), 3'b001, 8'd0}, cd + 3, cd + 8);
            end
            @(negedge clk);
            checks++;
            if (aborted !== 1'b0 || busy !== 1'b0 || brew_count !== count_before) begin
               errors++;
               $display("FAIL cancel_after aborted=%b busy=%b count=%0d expected 0 0 %0d",
                        aborted, busy, brew_count, count_before);
            end
            seen = 1;
            break;
         end
         checks++;
         if (got !== exp_q[k]) begin
            errors++;
            $display("FAIL brew_cycle k=%0d got=%h expected %h", k, got, exp_q[k]);
         end
         next_n   = !(mid_presses && k >= 10 && k < 16);
         select_n = !(mid_presses && k >= 20 && k < 26);
         cancel_n = !(do_cancel && k >= cd && k < cd + 5);
         @(negedge clk);
      end
      next_n = 1'b1;
      select_n = 1'b1;
      cancel_n = 1'b1;

      if (do_cancel) begin
         checks++;
         if (seen == 0) begin
            errors++;
            $display("FAIL cancel_seen aborted pulse missing expected one");
         end
      end else begin
         model_brews++;
         checks++;
         if (obs() !== {2'(model_sel), 11'd0} || brew_count !== exp_count()) begin
            errors++;
            $display("FAIL brew_end got=%h count=%0d expected %h count %0d",
                     obs(), brew_count, {2'(model_sel), 11'd0}, exp_count());
         end
      end
      repeat ($urandom_range(6, 12)) @(negedge clk);
   endtask

   task automatic test_reset();
      repeat (3) @(negedge clk);
      checks++;
      if (obs() !== 13'd0 || brew_count !== '0) begin
         errors++;
         $display("FAIL reset_state got=%h count=%0d expected 0 0", obs(), brew_count);
      end
      reset = 1'b0;
      repeat (4) @(negedge clk);
      checks++;
      if (obs() !== 13'd0) begin
         errors++;
         $display("FAIL reset_release got=%h expected 0", obs());
      end
   endtask

   task automatic test_recipe_cycle();
      for (int i = 0; i < 4; i++) begin
         press_next();
         checks++;
         if (recipe_sel !== 2'(model_sel)) begin
            errors++;
            $display("FAIL recipe_cycle press=%0d recipe_sel=%0d expected %0d", i, recipe_sel, model_sel);
         end
      end
      for (int g = 0; g < 2; g++) begin
         next_n = 1'b0;
         @(negedge clk);
         next_n = 1'b1;
         repeat ($urandom_range(8, 12)) @(negedge clk);
         checks++;
         if (recipe_sel !== 2'(model_sel)) begin
            errors++;
            $display("FAIL glitch recipe_sel=%0d expected %0d", recipe_sel, model_sel);
         end
      end
   endtask

   task automatic test_recipe0();
      goto_recipe(0);
      run_brew(1'b0, 1'b0);
   endtask

   task automatic test_recipe1_ignores_buttons();
      goto_recipe(1);
      run_brew(1'b1, 1'b0);
   endtask

   task automatic test_empty_mask();
      goto_recipe(2);
      run_brew(1'b0, 1'b0);
   endtask

   task automatic test_cancel();
      goto_recipe(1);
      run_brew(1'b0, 1'b1);
      run_brew(1'b0, 1'b0);
   endtask

   task automatic test_saturation();
      goto_recipe(2);
      run_brew(1'b0, 1'b0);
      checks++;
      if (brew_count !== CW'(CNT_MAX)) begin
         errors++;
         $display("FAIL saturation count=%0d expected %0d", brew_count, CNT_MAX);
      end
   endtask

   task automatic test_reset_midstep();
      int tmo;
      goto_recipe(1);
      select_n = 1'b0;
      tmo = 0;
      do begin
         @(negedge clk);
         tmo++;
      end while (busy !== 1'b1 && tmo < 20);
      select_n = 1'b1;
      repeat ($urandom_range(2, 6)) @(negedge clk);
      checks++;
      if (busy !== 1'b1 || valve === 5'd0) begin
         errors++;
         $display("FAIL midstep_pre busy=%b valve=%b expected busy 1 with a valve", busy, valve);
      end
      #2 reset = 1'b1;
      #1;
      model_sel = 0;
      model_brews = 0;
      checks++;
      if (obs() !== 13'd0 || brew_count !== '0) begin
         errors++;
         $display("FAIL async_reset got=%h count=%0d expected 0 0", obs(), brew_count);
      end
      @(negedge clk);
      reset = 1'b0;
      repeat (5) @(negedge clk);
      checks++;
      if (obs() !== 13'd0 || brew_count !== '0) begin
         errors++;
         $display("FAIL reset_idle got=%h count=%0d expected 0 0", obs(), brew_count);
      end
   endtask

   initial begin
      test_reset();
      test_recipe_cycle();
      test_recipe0();
      test_recipe1_ignores_buttons();
      test_empty_mask();
      test_cancel();
      test_saturation();
      test_reset_midstep();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog simulation time limit reached");
      $fatal(1, "watchdog");
   end

endmodule
